// File: rtl/ex_mem_pipe_pkg.sv
// Shared widths, load-type codes and FSM encoding for the dual-lane EX->MEM stage.
package ex_mem_pipe_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int LDTYPE_WIDTH  = 3;
    localparam int NUM_LANES     = 2;

    localparam logic [LDTYPE_WIDTH-1:0] LD_W  = 3'd0;
    localparam logic [LDTYPE_WIDTH-1:0] LD_H  = 3'd1;
    localparam logic [LDTYPE_WIDTH-1:0] LD_HU = 3'd2;
    localparam logic [LDTYPE_WIDTH-1:0] LD_B  = 3'd3;
    localparam logic [LDTYPE_WIDTH-1:0] LD_BU = 3'd4;

    typedef enum logic {
        EXMEM_RUN  = 1'b0,
        EXMEM_WAIT = 1'b1
    } exmem_state_e;
endpackage

// File: rtl/ex_mem_pipe_if.sv
// Two-lane D-cache request/response bundle; master = pipeline stage, slave = cache.
interface ex_mem_pipe_if;
    import ex_mem_pipe_pkg::*;

    logic [NUM_LANES-1:0]                 req;
    logic [NUM_LANES-1:0]                 we;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] addr;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata;
    logic [NUM_LANES-1:0]                 ack;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ex_mem_pipe_lane.sv
// One lane of the EX->MEM register: slot state, early-ack capture, D-cache request and
// forwarding load-data generation.
module ex_mem_pipe_lane
    import ex_mem_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     advance_i,
    input  logic                     flush_i,
    input  logic                     ex_valid_i,
    input  logic [RF_ADDR_WIDTH-1:0] ex_rdaddr_i,
    input  logic                     ex_rdwrten_i,
    input  logic                     ex_ld_i,
    input  logic                     ex_st_i,
    input  logic [LDTYPE_WIDTH-1:0]  ex_ldtype_i,
    input  logic [DATA_WIDTH-1:0]    ex_alu_i,
    input  logic [DATA_WIDTH-1:0]    ex_stdata_i,
    input  logic                     dc_ack_i,
    input  logic [DATA_WIDTH-1:0]    dc_rdata_i,
    output logic                     dc_req_o,
    output logic                     dc_we_o,
    output logic [DATA_WIDTH-1:0]    dc_addr_o,
    output logic [DATA_WIDTH-1:0]    dc_wdata_o,
    output logic                     exmem_valid_o,
    output logic [RF_ADDR_WIDTH-1:0] exmem_rdaddr_o,
    output logic                     exmem_rdwrten_o,
    output logic [LDTYPE_WIDTH-1:0]  exmem_ldtype_o,
    output logic [DATA_WIDTH-1:0]    exmem_alu_o,
    output logic                     mem_lden_o,
    output logic [DATA_WIDTH-1:0]    mem_rdata_o,
    output logic                     pending_o
);
    logic                     valid_q;
    logic [RF_ADDR_WIDTH-1:0] rdaddr_q;
    logic                     rdwrten_q;
    logic                     ld_q;
    logic                     st_q;
    logic [LDTYPE_WIDTH-1:0]  ldtype_q;
    logic [DATA_WIDTH-1:0]    alu_q;
    logic [DATA_WIDTH-1:0]    stdata_q;
    logic                     done_q;
    logic [DATA_WIDTH-1:0]    hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rdaddr_q  <= '0;
            rdwrten_q <= 1'b0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            ldtype_q  <= '0;
            alu_q     <= '0;
            stdata_q  <= '0;
            done_q    <= 1'b0;
            hold_q    <= '0;
        end else if (advance_i) begin
            valid_q   <= ex_valid_i & ~flush_i;
            rdaddr_q  <= ex_rdaddr_i;
            rdwrten_q <= ex_rdwrten_i;
            ld_q      <= ex_ld_i;
            st_q      <= ex_st_i;
            ldtype_q  <= ex_ldtype_i;
            alu_q     <= ex_alu_i;
            stdata_q  <= ex_stdata_i;
            done_q    <= 1'b0;
        end else if (pending_o && dc_ack_i) begin
            // Early finisher parks its response until the other lane catches up.
            done_q <= 1'b1;
            hold_q <= dc_rdata_i;
        end
    end

    assign pending_o       = valid_q & (ld_q | st_q) & ~done_q;
    assign dc_req_o        = pending_o;
    assign dc_we_o         = st_q;
    assign dc_addr_o       = alu_q;
    assign dc_wdata_o      = stdata_q;
    assign exmem_valid_o   = valid_q;
    assign exmem_rdaddr_o  = rdaddr_q;
    assign exmem_rdwrten_o = rdwrten_q;
    assign exmem_ldtype_o  = ldtype_q;
    assign exmem_alu_o     = alu_q;
    assign mem_lden_o      = valid_q & ld_q & (done_q | dc_ack_i);
    assign mem_rdata_o     = done_q ? hold_q : dc_rdata_i;
endmodule

// File: rtl/ex_mem_pipe.sv
// Dual-lane EX->MEM pipeline register with D-cache handshake and whole-pipe stall.
// Optional stall-cycle counter enabled by defining EXMEM_PERF_CNT_EN.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush_i,
    input  logic [NUM_LANES-1:0]                      ex_valid_i,
    input  logic [NUM_LANES-1:0][RF_ADDR_WIDTH-1:0]   ex_rdaddr_i,
    input  logic [NUM_LANES-1:0]                      ex_rdwrten_i,
    input  logic [NUM_LANES-1:0]                      ex_ld_i,
    input  logic [NUM_LANES-1:0]                      ex_st_i,
    input  logic [NUM_LANES-1:0][LDTYPE_WIDTH-1:0]    ex_ldtype_i,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      ex_alu_i,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      ex_stdata_i,
    ex_mem_pipe_if.master                             dc,
    output logic [NUM_LANES-1:0]                      exmem_valid_o,
    output logic [NUM_LANES-1:0][RF_ADDR_WIDTH-1:0]   exmem_rdaddr_o,
    output logic [NUM_LANES-1:0]                      exmem_rdwrten_o,
    output logic [NUM_LANES-1:0][LDTYPE_WIDTH-1:0]    exmem_ldtype_o,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      exmem_alu_o,
    output logic [NUM_LANES-1:0]                      mem_lden_o,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      mem_rdata_o,
    output logic                                      pipe_stall_o,
    output exmem_state_e                              fsm_state_o
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [31:0]                               perf_stall_cnt_o
`endif
);
    logic [NUM_LANES-1:0]                 pending;
    logic [NUM_LANES-1:0]                 dc_req;
    logic [NUM_LANES-1:0]                 dc_we;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] dc_addr;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] dc_wdata;
    logic                                 advance;
    exmem_state_e                         state_q, state_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            ex_mem_pipe_lane u_lane (
                .clk             (clk),
                .rst             (rst),
                .advance_i       (advance),
                .flush_i         (flush_i),
                .ex_valid_i      (ex_valid_i[gi]),
                .ex_rdaddr_i     (ex_rdaddr_i[gi]),
                .ex_rdwrten_i    (ex_rdwrten_i[gi]),
                .ex_ld_i         (ex_ld_i[gi]),
                .ex_st_i         (ex_st_i[gi]),
                .ex_ldtype_i     (ex_ldtype_i[gi]),
                .ex_alu_i        (ex_alu_i[gi]),
                .ex_stdata_i     (ex_stdata_i[gi]),
                .dc_ack_i        (dc.ack[gi]),
                .dc_rdata_i      (dc.rdata[gi]),
                .dc_req_o        (dc_req[gi]),
                .dc_we_o         (dc_we[gi]),
                .dc_addr_o       (dc_addr[gi]),
                .dc_wdata_o      (dc_wdata[gi]),
                .exmem_valid_o   (exmem_valid_o[gi]),
                .exmem_rdaddr_o  (exmem_rdaddr_o[gi]),
                .exmem_rdwrten_o (exmem_rdwrten_o[gi]),
                .exmem_ldtype_o  (exmem_ldtype_o[gi]),
                .exmem_alu_o     (exmem_alu_o[gi]),
                .mem_lden_o      (mem_lden_o[gi]),
                .mem_rdata_o     (mem_rdata_o[gi]),
                .pending_o       (pending[gi])
            );
        end
    endgenerate

    assign dc.req   = dc_req;
    assign dc.we    = dc_we;
    assign dc.addr  = dc_addr;
    assign dc.wdata = dc_wdata;

    // Stall is combinational from ack so a first-cycle ack costs no bubble.
    assign pipe_stall_o = |(pending & ~dc.ack);
    assign advance      = ~pipe_stall_o;
    assign fsm_state_o  = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= EXMEM_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EXMEM_RUN:  if (pipe_stall_o)  state_d = EXMEM_WAIT;
            EXMEM_WAIT: if (!pipe_stall_o) state_d = EXMEM_RUN;
            default:                       state_d = EXMEM_RUN;
        endcase
    end

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)               perf_cnt_q <= '0;
        else if (pipe_stall_o) perf_cnt_q <= perf_cnt_q + 32'd1;
    end

    assign perf_stall_cnt_o = perf_cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: per-cycle vector table plus hand-written stall sequences.
module tb_ex_mem_pipe;
    import ex_mem_pipe_pkg::*;

    logic                                    clk = 1'b0;
    logic                                    rst;
    logic                                    flush;
    logic [1:0]                              ex_valid, ex_rdwrten, ex_ld, ex_st;
    logic [1:0][RF_ADDR_WIDTH-1:0]           ex_rdaddr;
    logic [1:0][LDTYPE_WIDTH-1:0]            ex_ldtype;
    logic [1:0][DATA_WIDTH-1:0]              ex_alu, ex_stdata;
    logic [1:0]                              exmem_valid, exmem_rdwrten, mem_lden;
    logic [1:0][RF_ADDR_WIDTH-1:0]           exmem_rdaddr;
    logic [1:0][LDTYPE_WIDTH-1:0]            exmem_ldtype;
    logic [1:0][DATA_WIDTH-1:0]              exmem_alu, mem_rdata;
    logic                                    pipe_stall;
    exmem_state_e                            fsm_state;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0]                             perf_cnt;
`endif

    ex_mem_pipe_if dc_if ();

    ex_mem_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .ex_valid_i      (ex_valid),
        .ex_rdaddr_i     (ex_rdaddr),
        .ex_rdwrten_i    (ex_rdwrten),
        .ex_ld_i         (ex_ld),
        .ex_st_i         (ex_st),
        .ex_ldtype_i     (ex_ldtype),
        .ex_alu_i        (ex_alu),
        .ex_stdata_i     (ex_stdata),
        .dc              (dc_if.master),
        .exmem_valid_o   (exmem_valid),
        .exmem_rdaddr_o  (exmem_rdaddr),
        .exmem_rdwrten_o (exmem_rdwrten),
        .exmem_ldtype_o  (exmem_ldtype),
        .exmem_alu_o     (exmem_alu),
        .mem_lden_o      (mem_lden),
        .mem_rdata_o     (mem_rdata),
        .pipe_stall_o    (pipe_stall),
        .fsm_state_o     (fsm_state)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .perf_stall_cnt_o(perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [1:0]  val, ld, st, wen, ack;
        logic [4:0]  rd0, rd1;
        logic [31:0] alu0, alu1, sd0, rdin0;
        logic        x_stall;
        logic [1:0]  x_req, x_we, x_lden, x_val;
        logic [4:0]  x_rd0, x_rd1;
        logic [31:0] x_alu0, x_mrd0, x_mrd1;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        flush = 0; ex_valid = '0; ex_rdwrten = '0; ex_ld = '0; ex_st = '0;
        ex_rdaddr = '0; ex_ldtype = '0; ex_alu = '0; ex_stdata = '0;
        dc_if.ack = '0; dc_if.rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle table: scenario 1 (ALU bundle), 2 (first-cycle load ack),
        // 3 (load acked after 3 stall cycles with ALU partner).
        for (int i = 0; i < NV; i++) vecs[i] = '{default: '0};
        vecs[0].val = 2'b11; vecs[0].wen = 2'b11; vecs[0].rd0 = 5; vecs[0].rd1 = 6;
        vecs[0].alu0 = 32'h100; vecs[0].alu1 = 32'h200;
        vecs[1].val = 2'b01; vecs[1].ld = 2'b01; vecs[1].wen = 2'b01; vecs[1].rd0 = 7;
        vecs[1].alu0 = 32'h1000;
        vecs[1].x_val = 2'b11; vecs[1].x_rd0 = 5; vecs[1].x_rd1 = 6; vecs[1].x_alu0 = 32'h100;
        vecs[2].val = 2'b11; vecs[2].ld = 2'b01; vecs[2].wen = 2'b11; vecs[2].rd0 = 8;
        vecs[2].rd1 = 9; vecs[2].alu0 = 32'h2000; vecs[2].alu1 = 32'h300;
        vecs[2].ack = 2'b01; vecs[2].rdin0 = 32'hDEADBEEF;
        vecs[2].x_req = 2'b01; vecs[2].x_lden = 2'b01; vecs[2].x_mrd0 = 32'hDEADBEEF;
        vecs[2].x_val = 2'b01; vecs[2].x_rd0 = 7; vecs[2].x_alu0 = 32'h1000;
        for (int i = 3; i <= 6; i++) begin
            vecs[i].val = 2'b11; vecs[i].wen = 2'b11; vecs[i].rd0 = 10; vecs[i].rd1 = 11;
            vecs[i].alu0 = 32'h400;
            vecs[i].x_stall = (i != 6); vecs[i].x_req = 2'b01; vecs[i].x_val = 2'b11;
            vecs[i].x_rd0 = 8; vecs[i].x_rd1 = 9; vecs[i].x_alu0 = 32'h2000;
        end
        vecs[6].ack = 2'b01; vecs[6].rdin0 = 32'hCAFE0001;
        vecs[6].x_lden = 2'b01; vecs[6].x_mrd0 = 32'hCAFE0001;
        vecs[7].x_val = 2'b11; vecs[7].x_rd0 = 10; vecs[7].x_rd1 = 11; vecs[7].x_alu0 = 32'h400;

        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_vec++;
        chk("reset_stall", pipe_stall, 0);
        chk("reset_req", dc_if.req, 0);
        chk("reset_valid", exmem_valid, 0);
        chk("reset_lden", mem_lden, 0);
        chk("reset_state", fsm_state, EXMEM_RUN);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            flush = vecs[i].flush; ex_valid = vecs[i].val; ex_ld = vecs[i].ld;
            ex_st = vecs[i].st; ex_rdwrten = vecs[i].wen;
            ex_rdaddr[0] = vecs[i].rd0; ex_rdaddr[1] = vecs[i].rd1;
            ex_alu[0] = vecs[i].alu0; ex_alu[1] = vecs[i].alu1; ex_stdata[0] = vecs[i].sd0;
            dc_if.ack = vecs[i].ack; dc_if.rdata[0] = vecs[i].rdin0; dc_if.rdata[1] = '0;
            @(negedge clk);
            n_vec++;
            $display("vec %0d: stall=%0b req=%b lden=%b valid=%b rd0=%0d alu0=0x%08h mrd0=0x%08h",
                     i, pipe_stall, dc_if.req, mem_lden, exmem_valid, exmem_rdaddr[0],
                     exmem_alu[0], mem_rdata[0]);
            chk($sformatf("v%0d_stall", i), pipe_stall, vecs[i].x_stall);
            chk($sformatf("v%0d_req", i), dc_if.req, vecs[i].x_req);
            chk($sformatf("v%0d_we", i), dc_if.we, vecs[i].x_we);
            chk($sformatf("v%0d_lden", i), mem_lden, vecs[i].x_lden);
            chk($sformatf("v%0d_valid", i), exmem_valid, vecs[i].x_val);
            chk($sformatf("v%0d_rd0", i), exmem_rdaddr[0], vecs[i].x_rd0);
            chk($sformatf("v%0d_rd1", i), exmem_rdaddr[1], vecs[i].x_rd1);
            chk($sformatf("v%0d_alu0", i), exmem_alu[0], vecs[i].x_alu0);
            chk($sformatf("v%0d_addr0", i), dc_if.addr[0], vecs[i].x_alu0);
            chk($sformatf("v%0d_mrd0", i), mem_rdata[0], vecs[i].x_mrd0);
            chk($sformatf("v%0d_mrd1", i), mem_rdata[1], vecs[i].x_mrd1);
            next_cycle();
        end
`ifdef EXMEM_PERF_CNT_EN
        n_vec++;
        chk("perf_cnt_case3", perf_cnt, 3);
`endif

        // Both lanes load; lane1 acks in MEM cycle 1, lane0 in cycle 4.
        clr_in();
        ex_valid = 2'b11; ex_ld = 2'b11; ex_rdwrten = 2'b11;
        ex_rdaddr[0] = 12; ex_rdaddr[1] = 13; ex_alu[0] = 32'h40; ex_alu[1] = 32'h44;
        next_cycle();
        clr_in();
        ex_valid = 2'b01; ex_rdwrten = 2'b01; ex_rdaddr[0] = 20;
        for (int k = 1; k <= 4; k++) begin
            dc_if.ack = (k == 1) ? 2'b10 : (k == 4) ? 2'b01 : 2'b00;
            dc_if.rdata[1] = (k == 1) ? 32'h11 : 32'hFFFF;
            dc_if.rdata[0] = (k == 4) ? 32'h22 : 32'h0;
            @(negedge clk);
            n_vec++;
            $display("dual k=%0d: stall=%0b req=%b lden=%b mrd1=0x%08h", k, pipe_stall,
                     dc_if.req, mem_lden, mem_rdata[1]);
            chk($sformatf("dual%0d_stall", k), pipe_stall, (k != 4));
            chk($sformatf("dual%0d_lden1", k), mem_lden[1], 1);
            chk($sformatf("dual%0d_mrd1", k), mem_rdata[1], 32'h11);
            chk($sformatf("dual%0d_req", k), dc_if.req, (k == 1) ? 2'b11 : 2'b01);
            chk($sformatf("dual%0d_rd0", k), exmem_rdaddr[0], 12);
            if (k == 2) chk("dual2_state", fsm_state, EXMEM_WAIT);
            if (k == 4) begin
                chk("dual4_lden0", mem_lden[0], 1);
                chk("dual4_mrd0", mem_rdata[0], 32'h22);
            end
            next_cycle();
        end
        clr_in();
        @(negedge clk);
        n_vec++;
        chk("dual_adv_valid", exmem_valid, 2'b01);
        chk("dual_adv_rd0", exmem_rdaddr[0], 20);
        chk("dual_adv_lden", mem_lden, 0);
        next_cycle();

        // Store in WAIT with flush held until the advance cycle.
        clr_in();
        ex_valid = 2'b01; ex_st = 2'b01; ex_alu[0] = 32'h80; ex_stdata[0] = 32'h55;
        next_cycle();
        clr_in();
        flush = 1; ex_valid = 2'b11; ex_rdwrten = 2'b11;
        @(negedge clk);
        n_vec++;
        $display("store c1: stall=%0b req=%b we=%b wdata0=0x%08h", pipe_stall, dc_if.req,
                 dc_if.we, dc_if.wdata[0]);
        chk("st_c1_stall", pipe_stall, 1);
        chk("st_c1_req", dc_if.req, 2'b01);
        chk("st_c1_we", dc_if.we[0], 1);
        chk("st_c1_wdata", dc_if.wdata[0], 32'h55);
        chk("st_c1_addr", dc_if.addr[0], 32'h80);
        next_cycle();
        dc_if.ack = 2'b01;
        @(negedge clk);
        n_vec++;
        chk("st_c2_stall", pipe_stall, 0);
        chk("st_c2_req", dc_if.req, 2'b01);
        next_cycle();
        clr_in();
        @(negedge clk);
        n_vec++;
        $display("store c3: valid=%b req=%b", exmem_valid, dc_if.req);
        chk("st_c3_valid", exmem_valid, 2'b00);
        chk("st_c3_req", dc_if.req, 2'b00);
        next_cycle();

        // Reset while waiting on a load.
        clr_in();
        ex_valid = 2'b01; ex_ld = 2'b01; ex_rdwrten = 2'b01; ex_rdaddr[0] = 3;
        ex_alu[0] = 32'h90;
        next_cycle();
        clr_in();
        next_cycle();
        @(negedge clk);
        n_vec++;
        chk("rstw_stall", pipe_stall, 1);
        chk("rstw_state", fsm_state, EXMEM_WAIT);
        rst = 1;
        next_cycle();
        rst = 0;
        @(negedge clk);
        n_vec++;
        $display("after rst: stall=%0b req=%b valid=%b state=%0d", pipe_stall, dc_if.req,
                 exmem_valid, fsm_state);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_req", dc_if.req, 0);
        chk("rst_valid", exmem_valid, 0);
        chk("rst_lden", mem_lden, 0);
        chk("rst_rd0", exmem_rdaddr[0], 0);
        chk("rst_alu0", exmem_alu[0], 0);
        chk("rst_mrd0", mem_rdata[0], 0);
        chk("rst_state", fsm_state, EXMEM_RUN);
`ifdef EXMEM_PERF_CNT_EN
        chk("rst_perf", perf_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
